cache_lookup_ctrl: RTL and testbench

- Lookup/refill controller placed in front of the 4-way, 128-set, 19-bit-tag tag array.
- Accepts CPU read requests and drives the tag array's index. Compares the four returned tags and valid bits to detect a hit.
- Tracks tree pseudo-LRU state per set. On a miss it picks a victim, issues a line-refill request to memory, then writes the new tag and valid bit into the tag array through its write port.

---
 rtl/cache_lookup_ctrl_if.sv | 80 ++++++++
 rtl/cache_lookup_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_cache_lookup_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_lookup_ctrl_if.sv
// ----------------------------------------------------------------------------
// cache_lookup_ctrl_if
//
// Bundles every non-clock/reset signal of the cache lookup/refill controller:
//   - CPU request channel   : req_valid, req_ready, req_addr
//   - CPU response channel  : resp_valid, resp_ready, resp_hit, resp_way
//   - memory refill channel : mem_req_valid, mem_req_ready, mem_req_addr,
//                             mem_fill_done
//   - tag array ports       : ta_index, ta_tag_in, ta_write_enable,
//                             ta_write_way, ta_tag_out_0..3, ta_valid_bits
//   - statistics            : hit_count, miss_count
//
// Modports:
//   master - the lookup controller (drives index, refill, response, counters)
//   slave  - the surrounding CPU / memory / tag array environment
// ----------------------------------------------------------------------------
interface cache_lookup_ctrl_if #(
    parameter int ADDR_BITS  = 32,
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 19,
    parameter int CNT_BITS   = 16
);
    // CPU request
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_BITS-1:0]  req_addr;

    // CPU response
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_hit;
    logic [1:0]            resp_way;

    // Memory refill
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_BITS-1:0]  mem_req_addr;
    logic                  mem_fill_done;

    // Tag array
    logic [INDEX_BITS-1:0] ta_index;
    logic [TAG_BITS-1:0]   ta_tag_in;
    logic                  ta_write_enable;
    logic [1:0]            ta_write_way;
    logic [TAG_BITS-1:0]   ta_tag_out_0;
    logic [TAG_BITS-1:0]   ta_tag_out_1;
    logic [TAG_BITS-1:0]   ta_tag_out_2;
    logic [TAG_BITS-1:0]   ta_tag_out_3;
    logic [3:0]            ta_valid_bits;

    // Statistics
    logic [CNT_BITS-1:0]   hit_count;
    logic [CNT_BITS-1:0]   miss_count;

    modport master (
        input  req_valid, req_addr,
        output req_ready,
        output resp_valid, resp_hit, resp_way,
        input  resp_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_fill_done,
        output ta_index, ta_tag_in, ta_write_enable, ta_write_way,
        input  ta_tag_out_0, ta_tag_out_1, ta_tag_out_2, ta_tag_out_3,
        input  ta_valid_bits,
        output hit_count, miss_count
    );

    modport slave (
        output req_valid, req_addr,
        input  req_ready,
        input  resp_valid, resp_hit, resp_way,
        output resp_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_fill_done,
        input  ta_index, ta_tag_in, ta_write_enable, ta_write_way,
        output ta_tag_out_0, ta_tag_out_1, ta_tag_out_2, ta_tag_out_3,
        output ta_valid_bits,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/cache_lookup_ctrl.sv
// ----------------------------------------------------------------------------
// cache_lookup_ctrl
//
// Lookup/refill controller in front of a 4-way set-associative tag array.
// Accepts one CPU read at a time, indexes the tag array with the latched set
// index, compares the four returned tags to detect a hit, and on a miss picks
// a victim (first invalid way, otherwise tree pseudo-LRU), requests a line
// refill from memory and writes the new tag into the chosen way.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - asynchronous, active-high reset
//   bus    - cache_lookup_ctrl_if.master: CPU request/response, memory refill
//            handshake, tag array index/write/read ports, hit/miss counters
// ----------------------------------------------------------------------------
module cache_lookup_ctrl #(
    parameter int ADDR_BITS = 32,
    parameter int NUM_SETS  = 128,
    parameter int TAG_BITS  = 19,
    parameter int CNT_BITS  = 16
) (
    input logic                 clk,
    input logic                 reset,
    cache_lookup_ctrl_if.master bus
);

    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int OFFSET_BITS = ADDR_BITS - TAG_BITS - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL,
        RESP
    } state_t;

    state_t                state;
    state_t                state_next;

    // Latched request fields; the byte offset is never needed.
    logic [TAG_BITS-1:0]   lat_tag;
    logic [INDEX_BITS-1:0] lat_index;

    // Tree PLRU per set: bit 0 = root (b0), bit 1 = left pair (b1),
    // bit 2 = right pair (b2).
    logic [2:0]            plru [NUM_SETS];
    logic [2:0]            cur_plru;

    logic [1:0]            victim_way;
    logic                  resp_hit_q;
    logic [1:0]            resp_way_q;
    logic [CNT_BITS-1:0]   hit_cnt;
    logic [CNT_BITS-1:0]   miss_cnt;

    logic [TAG_BITS-1:0]   way_tag [4];
    logic [3:0]            hit_vec;
    logic                  any_hit;
    logic [1:0]            hit_way;
    logic [1:0]            lookup_victim;

    logic                  unused_offset;
    assign unused_offset = ^bus.req_addr[OFFSET_BITS-1:0];

    // ------------------------------------------------------------------------
    // PLRU helpers
    // ------------------------------------------------------------------------
    // Victim walks away from the most recently used half / way.
    function automatic logic [1:0] plru_victim(input logic [2:0] bits);
        if (!bits[0]) begin
            plru_victim = bits[1] ? 2'd1 : 2'd0;
        end else begin
            plru_victim = bits[2] ? 2'd3 : 2'd2;
        end
    endfunction

    // Point the tree away from the way just used; the untouched pair bit keeps
    // its history.
    function automatic logic [2:0] plru_touch(input logic [2:0] bits,
                                              input logic [1:0] way);
        plru_touch = bits;
        case (way)
            2'd0:    begin plru_touch[0] = 1'b1; plru_touch[1] = 1'b1; end
            2'd1:    begin plru_touch[0] = 1'b1; plru_touch[1] = 1'b0; end
            2'd2:    begin plru_touch[0] = 1'b0; plru_touch[2] = 1'b1; end
            default: begin plru_touch[0] = 1'b0; plru_touch[2] = 1'b0; end
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Hit detection and victim selection (combinational from tag array data)
    // ------------------------------------------------------------------------
    assign way_tag[0] = bus.ta_tag_out_0;
    assign way_tag[1] = bus.ta_tag_out_1;
    assign way_tag[2] = bus.ta_tag_out_2;
    assign way_tag[3] = bus.ta_tag_out_3;

    assign cur_plru = plru[lat_index];

    // NOTE: every variable written here gets a default before any condition,
    // otherwise a path that skips the assignment would infer a latch.
    always_comb begin
        hit_vec       = '0;
        hit_way       = 2'd0;
        lookup_victim = plru_victim(cur_plru);
        for (int w = 0; w < 4; w++) begin
            hit_vec[w] = bus.ta_valid_bits[w] && (way_tag[w] == lat_tag);
        end
        // Scan downwards so the lowest-numbered match wins.
        for (int w = 3; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = 2'(w);
            end
            if (!bus.ta_valid_bits[w]) begin
                lookup_victim = 2'(w);
            end
        end
    end

    assign any_hit = |hit_vec;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.req_valid)     state_next = LOOKUP;
            LOOKUP:    state_next = any_hit ? RESP : MISS_REQ;
            MISS_REQ:  if (bus.mem_req_ready) state_next = MISS_WAIT;
            MISS_WAIT: if (bus.mem_fill_done) state_next = FILL;
            FILL:      state_next = RESP;
            RESP:      if (bus.resp_ready)    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        bus.req_ready       = 1'b0;
        bus.resp_valid      = 1'b0;
        bus.mem_req_valid   = 1'b0;
        bus.ta_write_enable = 1'b0;
        case (state)
            IDLE:     bus.req_ready       = 1'b1;
            MISS_REQ: bus.mem_req_valid   = 1'b1;
            FILL:     bus.ta_write_enable = 1'b1;
            RESP:     bus.resp_valid      = 1'b1;
            default:  ;
        endcase
    end

    // All remaining outputs come straight from registers, so reset clears them
    // without waiting for a clock edge.
    assign bus.ta_index     = lat_index;
    assign bus.ta_tag_in    = lat_tag;
    assign bus.ta_write_way = victim_way;
    assign bus.mem_req_addr = {lat_tag, lat_index, {OFFSET_BITS{1'b0}}};
    assign bus.resp_hit     = resp_hit_q;
    assign bus.resp_way     = resp_way_q;
    assign bus.hit_count    = hit_cnt;
    assign bus.miss_count   = miss_cnt;

    // ------------------------------------------------------------------------
    // Datapath: request latch, victim, response fields, PLRU, counters
    // ------------------------------------------------------------------------
    // NOTE: the PLRU table is built from flops rather than a RAM macro, so it
    // can and must be cleared by reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_tag    <= '0;
            lat_index  <= '0;
            victim_way <= 2'd0;
            resp_hit_q <= 1'b0;
            resp_way_q <= 2'd0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                plru[s] <= 3'b000;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_tag   <= bus.req_addr[ADDR_BITS-1 -: TAG_BITS];
                        lat_index <= bus.req_addr[OFFSET_BITS +: INDEX_BITS];
                    end
                end
                LOOKUP: begin
                    if (any_hit) begin
                        resp_hit_q      <= 1'b1;
                        resp_way_q      <= hit_way;
                        plru[lat_index] <= plru_touch(cur_plru, hit_way);
                        if (hit_cnt != '1) begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                    end else begin
                        victim_way <= lookup_victim;
                        if (miss_cnt != '1) begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                end
                FILL: begin
                    resp_hit_q      <= 1'b0;
                    resp_way_q      <= victim_way;
                    plru[lat_index] <= plru_touch(cur_plru, victim_way);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cache_lookup_ctrl
//
// Drives cache_lookup_ctrl through directed and randomized read traffic. A
// tag array is emulated around the DUT; expected responses, victims, refill
// addresses and counters come from an independent cache model that tracks
// per-set contents and a tree pseudo-LRU described as "which half / which way
// of a pair is next to go".
// ----------------------------------------------------------------------------
module tb_cache_lookup_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    cache_lookup_ctrl_if bus ();

    cache_lookup_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Tag array emulation (written only by the DUT's write port)
    // ------------------------------------------------------------------------
    logic [18:0] env_tag   [128][4];
    logic [3:0]  env_valid [128];

    assign bus.ta_tag_out_0  = env_tag[bus.ta_index][0];
    assign bus.ta_tag_out_1  = env_tag[bus.ta_index][1];
    assign bus.ta_tag_out_2  = env_tag[bus.ta_index][2];
    assign bus.ta_tag_out_3  = env_tag[bus.ta_index][3];
    assign bus.ta_valid_bits = env_valid[bus.ta_index];

    always @(posedge clk) begin
        if (bus.ta_write_enable) begin
            env_tag[bus.ta_index][bus.ta_write_way]   <= bus.ta_tag_in;
            env_valid[bus.ta_index][bus.ta_write_way] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Reference cache model
    // ------------------------------------------------------------------------
    logic [18:0] m_tag   [128][4];
    logic [3:0]  m_valid [128];
    bit          m_evict_right [128];  // next victim comes from ways 2/3
    bit          m_left_pick1  [128];  // within ways 0/1, way 1 goes next
    bit          m_right_pick3 [128];  // within ways 2/3, way 3 goes next
    int          m_hits;
    int          m_misses;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_victim(input int idx);
        for (int w = 0; w < 4; w++) begin
            if (!m_valid[idx][w]) return w;
        end
        if (m_evict_right[idx]) return m_right_pick3[idx] ? 3 : 2;
        return m_left_pick1[idx] ? 1 : 0;
    endfunction

    // Using a way protects it: send the next eviction to the other half and
    // to the other way of the used pair.
    task automatic model_use(input int idx, input int way);
        if (way < 2) begin
            m_evict_right[idx] = 1'b1;
            m_left_pick1[idx]  = (way == 0);
        end else begin
            m_evict_right[idx] = 1'b0;
            m_right_pick3[idx] = (way == 2);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 128; s++) begin
            m_evict_right[s] = 1'b0;
            m_left_pick1[s]  = 1'b0;
            m_right_pick3[s] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // ------------------------------------------------------------------------
    // One complete read transaction. Called and returning at a falling edge.
    // ------------------------------------------------------------------------
    task automatic do_req(input logic [31:0] addr, input int mem_delay,
                          input int fill_delay, input int resp_delay,
                          input bit stray_req, output logic [1:0] got_way);
        int          idx;
        logic [18:0] tg;
        bit          exp_hit;
        int          exp_way;
        logic [31:0] line;
        logic        seen_hit;

        idx     = int'(addr[12:6]);
        tg      = addr[31:13];
        line    = addr & 32'hFFFF_FFC0;
        exp_hit = 1'b0;
        exp_way = 0;
        for (int w = 3; w >= 0; w--) begin
            if (m_valid[idx][w] && m_tag[idx][w] == tg) begin
                exp_hit = 1'b1;
                exp_way = w;
            end
        end
        if (!exp_hit) exp_way = model_victim(idx);

        check("req_ready_idle", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;

        // LOOKUP
        check("lookup_index", 32'(bus.ta_index), 32'(idx));
        check("lookup_no_mem_req", 32'(bus.mem_req_valid), 0);

        if (!exp_hit) begin
            @(negedge clk);
            check("miss_mem_req_valid", 32'(bus.mem_req_valid), 1);
            check("miss_mem_req_addr", bus.mem_req_addr, line);
            for (int i = 0; i < mem_delay; i++) begin
                @(negedge clk);
                check("mem_req_valid_hold", 32'(bus.mem_req_valid), 1);
                check("mem_req_addr_hold", bus.mem_req_addr, line);
            end
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            check("single_mem_handshake", 32'(bus.mem_req_valid), 0);
            for (int i = 0; i < fill_delay; i++) begin
                @(negedge clk);
                check("no_write_before_fill", 32'(bus.ta_write_enable), 0);
            end
            bus.mem_fill_done = 1'b1;
            @(negedge clk);
            bus.mem_fill_done = 1'b0;
            check("fill_write_enable", 32'(bus.ta_write_enable), 1);
            check("fill_write_way", 32'(bus.ta_write_way), 32'(exp_way));
            check("fill_tag_in", 32'(bus.ta_tag_in), 32'(tg));
            check("fill_index", 32'(bus.ta_index), 32'(idx));
        end

        // RESP: a hit arrives exactly two cycles after acceptance.
        @(negedge clk);
        check("resp_valid", 32'(bus.resp_valid), 1);
        check("resp_hit", 32'(bus.resp_hit), 32'(exp_hit));
        check("resp_way", 32'(bus.resp_way), 32'(exp_way));
        check("resp_no_write", 32'(bus.ta_write_enable), 0);
        if (exp_hit) check("hit_no_mem_req", 32'(bus.mem_req_valid), 0);
        got_way  = bus.resp_way;
        seen_hit = bus.resp_hit;

        for (int i = 0; i < resp_delay; i++) begin
            bus.req_valid = stray_req;
            bus.req_addr  = addr ^ 32'h0000_2000;
            @(negedge clk);
            check("resp_valid_hold", 32'(bus.resp_valid), 1);
            check("resp_hit_hold", 32'(bus.resp_hit), 32'(seen_hit));
            check("resp_way_hold", 32'(bus.resp_way), 32'(got_way));
            check("req_ready_busy", 32'(bus.req_ready), 0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("resp_consumed", 32'(bus.resp_valid), 0);
        check("back_to_idle", 32'(bus.req_ready), 1);

        if (exp_hit) begin
            m_hits++;
        end else begin
            m_misses++;
            m_tag[idx][exp_way]   = tg;
            m_valid[idx][exp_way] = 1'b1;
        end
        model_use(idx, exp_way);
        check("hit_count", 32'(bus.hit_count), 32'(m_hits));
        check("miss_count", 32'(bus.miss_count), 32'(m_misses));
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(bus.req_ready), 1);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_resp_hit", 32'(bus.resp_hit), 0);
        check("rst_resp_way", 32'(bus.resp_way), 0);
        check("rst_mem_req_valid", 32'(bus.mem_req_valid), 0);
        check("rst_mem_req_addr", bus.mem_req_addr, 0);
        check("rst_ta_index", 32'(bus.ta_index), 0);
        check("rst_ta_write_enable", 32'(bus.ta_write_enable), 0);
        check("rst_hit_count", 32'(bus.hit_count), 0);
        check("rst_miss_count", 32'(bus.miss_count), 0);
    endtask

    // Safety net: every wait below is already bounded.
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [1:0]  way;
        logic [31:0] addr;

        for (int s = 0; s < 128; s++) begin
            env_valid[s] = 4'b0000;
            m_valid[s]   = 4'b0000;
            for (int w = 0; w < 4; w++) begin
                env_tag[s][w] = '0;
                m_tag[s][w]   = '0;
            end
        end
        model_reset();
        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.resp_ready    = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_fill_done = 1'b0;

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        @(negedge clk);

        // First read misses into way 0, then hits there.
        do_req(32'h0000_1040, 0, 0, 0, 1'b0, way);
        check("first_miss_way0", 32'(way), 0);
        do_req(32'h0000_1040, 0, 0, 0, 1'b0, way);
        check("repeat_hit_way0", 32'(way), 0);

        // Fill the remaining ways of set 65, then force a PLRU eviction.
        do_req(32'h0000_3040, 0, 1, 0, 1'b0, way);
        check("fill_way1", 32'(way), 1);
        do_req(32'h0000_5040, 1, 0, 0, 1'b0, way);
        check("fill_way2", 32'(way), 2);
        do_req(32'h0000_7040, 0, 2, 0, 1'b0, way);
        check("fill_way3", 32'(way), 3);
        do_req(32'h0000_9040, 0, 0, 0, 1'b0, way);
        check("plru_victim_way0", 32'(way), 0);

        // Memory back-pressure, then CPU back-pressure with a stray request.
        do_req(32'h0000_B080, 5, 0, 0, 1'b0, way);
        do_req(32'h0000_3040, 0, 0, 4, 1'b1, way);
        check("stalled_hit_way1", 32'(way), 1);

        // Randomized traffic over a few sets and a handful of tags.
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 2))
                0:       addr[12:6] = 7'd65;
                1:       addr[12:6] = 7'd127;
                default: addr[12:6] = 7'($urandom_range(0, 3));
            endcase
            addr[31:13] = 19'($urandom_range(0, 5));
            addr[5:0]   = 6'($urandom_range(0, 63));
            do_req(addr, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), way);
        end

        // Reset in the middle of a refill, away from any clock edge.
        addr = 32'h000F_0000 | (32'd9 << 6);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_mem_req_valid", 32'(bus.mem_req_valid), 1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        bus.mem_fill_done = 1'b1;
        @(negedge clk);
        bus.mem_fill_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_fill_no_write", 32'(bus.ta_write_enable), 0);
            check("late_fill_idle", 32'(bus.req_ready), 1);
            @(negedge clk);
        end
        check("late_fill_valid_bits", 32'(env_valid[9]), 32'(m_valid[9]));
        check("post_reset_hit_count", 32'(bus.hit_count), 0);
        check("post_reset_miss_count", 32'(bus.miss_count), 0);

        // Controller works normally afterwards.
        do_req(addr, 1, 1, 1, 1'b0, way);
        do_req(addr, 0, 0, 0, 1'b0, way);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
